// File: rtl/loac_io_pkg.sv
// rtl/loac_io_pkg.sv - shared constants and helpers for switch input conditioning
package loac_io_pkg;

   localparam int NBITS_TOP               = 8;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

   // Counter must hold 0..DEBOUNCE_CYCLES-1; one spare code keeps width >= 1
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one-bit synchroniser, stability filter and edge pulses
module debounce_bit
   import loac_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk_2,
   input  logic reset,
   input  logic raw_i,
   output logic db_o,
   output logic rise_o,
   output logic fall_o,
   output logic pulse_next_o
);

   localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db_q, db_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   // Two-flop synchroniser; nothing may sit between the stages
   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= raw_i;
         s2_q <= s1_q;
      end
   end

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges in a row
   always_comb begin
      cnt_d  = '0;
      db_d   = db_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d   = s2_q;
            rise_d = s2_q;
            fall_d = ~s2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Filter state and pulse registers; pulses fall back to 0 every cycle
   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         db_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         db_q   <= db_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign db_o         = db_q;
   assign rise_o       = rise_q;
   assign fall_o       = fall_q;
   // Lets the parent register an aggregate flag on the same edge as the pulses
   assign pulse_next_o = rise_d | fall_d;

endmodule

// File: rtl/swi_debouncer.sv
// rtl/swi_debouncer.sv - slide-switch bus debouncer with rise/fall/changed pulses
module swi_debouncer
   import loac_io_pkg::*;
#(
   parameter int NBITS           = NBITS_TOP,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic             clk_2,
   input  logic             reset,
   input  logic [NBITS-1:0] swi_raw,
   output logic [NBITS-1:0] swi_db,
   output logic [NBITS-1:0] swi_rise,
   output logic [NBITS-1:0] swi_fall,
   output logic             swi_changed
);

   logic [NBITS-1:0] pulse_next;
   logic             changed_q;

   for (genvar i = 0; i < NBITS; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clk_2        (clk_2),
         .reset        (reset),
         .raw_i        (swi_raw[i]),
         .db_o         (swi_db[i]),
         .rise_o       (swi_rise[i]),
         .fall_o       (swi_fall[i]),
         .pulse_next_o (pulse_next[i])
      );
   end

   // One changed pulse per cycle no matter how many bits switch together
   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         changed_q <= 1'b0;
      end else begin
         changed_q <= |pulse_next;
      end
   end

   assign swi_changed = changed_q;

endmodule

// File: tb/tb_swi_debouncer.sv
// tb/tb_swi_debouncer.sv - self-checking bench for swi_debouncer (D=4 and D=1)
module tb_swi_debouncer;

   logic       clk_2;
   logic       reset;
   logic [7:0] swi_raw;
   logic [7:0] db0, rise0, fall0;
   logic       chg0;
   logic [7:0] db1, rise1, fall1;
   logic       chg1;

   int total = 0;
   int bad   = 0;

   swi_debouncer #(.NBITS(8), .DEBOUNCE_CYCLES(4)) dut0 (
      .clk_2       (clk_2),
      .reset       (reset),
      .swi_raw     (swi_raw),
      .swi_db      (db0),
      .swi_rise    (rise0),
      .swi_fall    (fall0),
      .swi_changed (chg0)
   );

   swi_debouncer #(.NBITS(8), .DEBOUNCE_CYCLES(1)) dut1 (
      .clk_2       (clk_2),
      .reset       (reset),
      .swi_raw     (swi_raw),
      .swi_db      (db1),
      .swi_rise    (rise1),
      .swi_fall    (fall1),
      .swi_changed (chg1)
   );

   initial clk_2 = 1'b0;
   always #5 clk_2 = ~clk_2;

   // Reference model: history of raw values per edge since reset; a bit flips
   // when its last D filter samples (raw delayed two edges) all differ from the
   // debounced level and all lie after its previous flip.
   logic [7:0] hist[$];
   int         n;
   int         dcyc[2];
   logic [7:0] db_m[2], rise_m[2], fall_m[2];
   logic       chg_m[2];
   int         last_chg[2][8];

   function automatic logic fbit(input int e, input int b);
      if (e < 2) return 1'b0;
      return hist[e-2][b];
   endfunction

   task automatic model_reset();
      hist.delete();
      n = 0;
      for (int k = 0; k < 2; k++) begin
         db_m[k] = 8'h00; rise_m[k] = 8'h00; fall_m[k] = 8'h00; chg_m[k] = 1'b0;
         for (int b = 0; b < 8; b++) last_chg[k][b] = -1;
      end
   endtask

   task automatic model_edge();
      hist.push_back(swi_raw);
      for (int k = 0; k < 2; k++) begin
         rise_m[k] = 8'h00;
         fall_m[k] = 8'h00;
         for (int b = 0; b < 8; b++) begin
            logic flip;
            flip = 1'b1;
            for (int j = 0; j < dcyc[k]; j++) begin
               int e;
               e = n - j;
               if (e <= last_chg[k][b] || fbit(e, b) == db_m[k][b]) flip = 1'b0;
            end
            if (flip) begin
               db_m[k][b] = ~db_m[k][b];
               if (db_m[k][b]) rise_m[k][b] = 1'b1;
               else            fall_m[k][b] = 1'b1;
               last_chg[k][b] = n;
            end
         end
         chg_m[k] = |(rise_m[k] | fall_m[k]);
      end
      n++;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("m0_db",   db0,   db_m[0]);
      chk("m0_rise", rise0, rise_m[0]);
      chk("m0_fall", fall0, fall_m[0]);
      chk("m0_chg",  {7'd0, chg0}, {7'd0, chg_m[0]});
      chk("m1_db",   db1,   db_m[1]);
      chk("m1_rise", rise1, rise_m[1]);
      chk("m1_fall", fall1, fall_m[1]);
      chk("m1_chg",  {7'd0, chg1}, {7'd0, chg_m[1]});
   endtask

   task automatic tick();
      @(posedge clk_2);
      if (!reset) model_edge();
      @(negedge clk_2);
      check_model();
   endtask

   task automatic ticks(input int cnt);
      for (int t = 0; t < cnt; t++) tick();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_db"},   db0,   8'h00);
      chk({tag, "_rise"}, rise0, 8'h00);
      chk({tag, "_fall"}, fall0, 8'h00);
      chk({tag, "_chg"},  {7'd0, chg0}, 8'h00);
   endtask

   initial begin
      int lat;
      dcyc[0] = 4;
      dcyc[1] = 1;
      swi_raw = 8'hFF;
      reset   = 1'b1;
      model_reset();
      #1;
      // 1: reset with all switches high, then release before edge 0
      check_zero("t1_rst");
      tick();
      check_zero("t1_rst_edge");
      reset = 1'b0;
      ticks(5);
      chk("t1_db_pre", db0, 8'h00);
      tick();
      chk("t1_db",   db0,   8'hFF);
      chk("t1_rise", rise0, 8'hFF);
      chk("t1_chg",  {7'd0, chg0}, 8'h01);
      tick();
      chk("t1_rise_end", rise0, 8'h00);
      chk("t1_chg_end",  {7'd0, chg0}, 8'h00);

      // 2: glitch on bit 3 shorter than the filter window
      swi_raw = 8'h00;
      ticks(8);
      chk("t2_start", db0, 8'h00);
      swi_raw = 8'h08;
      ticks(3);
      swi_raw = 8'h00;
      for (int t = 0; t < 8; t++) begin
         tick();
         chk("t2_db",    db0,   8'h00);
         chk("t2_pulse", rise0 | fall0 | {7'd0, chg0}, 8'h00);
      end

      // 3: single-bit rise then fall
      swi_raw = 8'h01;
      ticks(5);
      chk("t3_db_pre", db0, 8'h00);
      tick();
      chk("t3_db_up",  db0,   8'h01);
      chk("t3_rise",   rise0, 8'h01);
      tick();
      chk("t3_rise_end", rise0, 8'h00);
      swi_raw = 8'h00;
      ticks(5);
      chk("t3_db_hold", db0, 8'h01);
      tick();
      chk("t3_db_dn", db0,   8'h00);
      chk("t3_fall",  fall0, 8'h01);
      tick();
      chk("t3_fall_end", fall0, 8'h00);

      // 4: simultaneous rise on bit 7 and fall on bit 1
      swi_raw = 8'h02;
      ticks(8);
      chk("t4_start", db0, 8'h02);
      swi_raw = 8'h80;
      ticks(5);
      chk("t4_db_pre", db0, 8'h02);
      tick();
      chk("t4_db",   db0,   8'h80);
      chk("t4_rise", rise0, 8'h80);
      chk("t4_fall", fall0, 8'h02);
      chk("t4_chg",  {7'd0, chg0}, 8'h01);
      tick();
      chk("t4_chg_end", {7'd0, chg0}, 8'h00);

      // 5: reset while bit 5 is mid-count, then measure release-to-rise latency
      swi_raw = 8'hA0;
      ticks(4);
      reset = 1'b1;
      model_reset();
      #1;
      check_zero("t5_async");
      @(negedge clk_2);
      tick();
      check_zero("t5_held");
      reset = 1'b0;
      lat = 0;
      for (int t = 1; t <= 20; t++) begin
         tick();
         if (rise0[5]) begin
            lat = t;
            break;
         end
      end
      chk("t5_latency", 8'(lat), 8'd6);

      // 6: D=1 instance on a multi-bit change
      swi_raw = 8'h00;
      ticks(10);
      chk("t6_start", db1, 8'h00);
      swi_raw = 8'h55;
      ticks(2);
      chk("t6_db_pre", db1, 8'h00);
      tick();
      chk("t6_db",   db1,   8'h55);
      chk("t6_rise", rise1, 8'h55);
      tick();
      chk("t6_rise_end", rise1, 8'h00);

      // Random switch activity with occasional resets, checked against the model
      for (int t = 0; t < 600; t++) begin
         if ($urandom_range(0, 199) == 0) begin
            reset = 1'b1;
            model_reset();
            #1;
            check_zero("rnd_rst");
            tick();
            reset = 1'b0;
         end else begin
            if ($urandom_range(0, 3) == 0) swi_raw = 8'($urandom);
            else if ($urandom_range(0, 5) == 0) swi_raw = swi_raw ^ (8'h01 << $urandom_range(0, 7));
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
